// File: rtl/control_sequencer.sv
// SAP-1 control unit: one-hot T1..T6 ring, combinational strobe decode, ALU flag register.
// Strobes are valid in the same cycle as their T state; en=0 or halted freezes the ring with all strobes low.
module control_sequencer #(
  parameter int                OPW    = 4,
  parameter logic [OPW-1:0]    OP_LDA = 4'h0,
  parameter logic [OPW-1:0]    OP_ADD = 4'h1,
  parameter logic [OPW-1:0]    OP_SUB = 4'h2,
  parameter logic [OPW-1:0]    OP_JMP = 4'h3,
  parameter logic [OPW-1:0]    OP_JC  = 4'h4,
  parameter logic [OPW-1:0]    OP_JZ  = 4'h5,
  parameter logic [OPW-1:0]    OP_OUT = 4'hE,
  parameter logic [OPW-1:0]    OP_HLT = 4'hF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  input  logic           alu_carry,
  input  logic           alu_zero,
  output logic           pc_out,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mar_load,
  output logic           ram_out,
  output logic           ir_load,
  output logic           ir_out,
  output logic           a_load,
  output logic           a_out,
  output logic           b_load,
  output logic           out_load,
  output logic           alu_sum,
  output logic           alu_sub,
  output logic           alu_out,
  output logic [5:0]     t_state,
  output logic           flag_c,
  output logic           flag_z,
  output logic           halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic out_load;
    logic alu_sum;
    logic alu_sub;
    logic alu_out;
  } ctrl_t;

  tstate_e state_q, state_d;
  logic    halted_d, flag_c_d, flag_z_d;
  ctrl_t   ctrl;
  logic    is_alu_op, jump_taken;

  assign is_alu_op  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign jump_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JC) && flag_c) ||
                      ((opcode == OP_JZ) && flag_z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T1;
      halted  <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= halted_d;
      flag_c  <= flag_c_d;
      flag_z  <= flag_z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted;
    flag_c_d = flag_c;
    flag_z_d = flag_z;
    ctrl     = '0;
    if (en && !halted) begin
      case (state_q)
        T1: begin
          ctrl.pc_out   = 1'b1;
          ctrl.mar_load = 1'b1;
          state_d       = T2;
        end
        T2: begin
          ctrl.pc_inc = 1'b1;
          state_d     = T3;
        end
        T3: begin
          ctrl.ram_out = 1'b1;
          ctrl.ir_load = 1'b1;
          state_d      = T4;
        end
        T4: begin
          state_d = T5;
          if ((opcode == OP_LDA) || is_alu_op) begin
            ctrl.ir_out   = 1'b1;
            ctrl.mar_load = 1'b1;
          end else if (jump_taken) begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            ctrl.a_out    = 1'b1;
            ctrl.out_load = 1'b1;
          end else if (opcode == OP_HLT) begin
            // Park in T4 for good; only reset brings the ring back.
            halted_d = 1'b1;
            state_d  = T4;
          end
        end
        T5: begin
          state_d = T6;
          if (opcode == OP_LDA) begin
            ctrl.ram_out = 1'b1;
            ctrl.a_load  = 1'b1;
          end else if (is_alu_op) begin
            ctrl.ram_out = 1'b1;
            ctrl.b_load  = 1'b1;
          end
        end
        T6: begin
          state_d = T1;
          if (is_alu_op) begin
            ctrl.alu_out = 1'b1;
            ctrl.a_load  = 1'b1;
            ctrl.alu_sum = (opcode == OP_ADD);
            ctrl.alu_sub = (opcode == OP_SUB);
            // Flags capture on the same edge that writes the ALU result into A.
            flag_c_d     = alu_carry;
            flag_z_d     = alu_zero;
          end
        end
        default: state_d = T1;
      endcase
    end
  end

  // Reset is asynchronous, so the strobes are gated by it directly rather than waiting for a clock.
  assign pc_out   = ctrl.pc_out   & rst_n;
  assign pc_inc   = ctrl.pc_inc   & rst_n;
  assign pc_load  = ctrl.pc_load  & rst_n;
  assign mar_load = ctrl.mar_load & rst_n;
  assign ram_out  = ctrl.ram_out  & rst_n;
  assign ir_load  = ctrl.ir_load  & rst_n;
  assign ir_out   = ctrl.ir_out   & rst_n;
  assign a_load   = ctrl.a_load   & rst_n;
  assign a_out    = ctrl.a_out    & rst_n;
  assign b_load   = ctrl.b_load   & rst_n;
  assign out_load = ctrl.out_load & rst_n;
  assign alu_sum  = ctrl.alu_sum  & rst_n;
  assign alu_sub  = ctrl.alu_sub  & rst_n;
  assign alu_out  = ctrl.alu_out  & rst_n;
  assign t_state  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instruction sequences and compares strobes, ring state and flags.
module tb_control_sequencer;

  localparam logic [13:0] PC_OUT   = 14'h2000;
  localparam logic [13:0] PC_INC   = 14'h1000;
  localparam logic [13:0] PC_LOAD  = 14'h0800;
  localparam logic [13:0] MAR_LOAD = 14'h0400;
  localparam logic [13:0] RAM_OUT  = 14'h0200;
  localparam logic [13:0] IR_LOAD  = 14'h0100;
  localparam logic [13:0] IR_OUT   = 14'h0080;
  localparam logic [13:0] A_LOAD   = 14'h0040;
  localparam logic [13:0] A_OUT    = 14'h0020;
  localparam logic [13:0] B_LOAD   = 14'h0010;
  localparam logic [13:0] OUT_LOAD = 14'h0008;
  localparam logic [13:0] ALU_SUM  = 14'h0004;
  localparam logic [13:0] ALU_SUB  = 14'h0002;
  localparam logic [13:0] ALU_OUT  = 14'h0001;
  localparam logic [13:0] NONE     = 14'h0000;

  logic       clk = 1'b0;
  logic       rst_n, en, alu_carry, alu_zero;
  logic [3:0] opcode;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, out_load, alu_sum, alu_sub, alu_out;
  logic [5:0] t_state;
  logic       flag_c, flag_z, halted;
  logic [13:0] strb;

  int checks = 0;
  int errors = 0;
  logic fc_m = 1'b0;
  logic fz_m = 1'b0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .out_load(out_load), .alu_sum(alu_sum),
    .alu_sub(alu_sub), .alu_out(alu_out), .t_state(t_state),
    .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
  );

  assign strb = {pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
                 a_load, a_out, b_load, out_load, alu_sum, alu_sub, alu_out};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n_states T states of one instruction starting from T1; the opcode and ALU
  // inputs carry decoy values outside the states where they are meant to matter.
  task automatic instr(input string tag, input logic [3:0] op,
                       input logic [13:0] e4, input logic [13:0] e5, input logic [13:0] e6,
                       input logic c, input logic z, input int freeze_at, input int n_states);
    logic [13:0] exp_s [6];
    exp_s = '{PC_OUT | MAR_LOAD, PC_INC, RAM_OUT | IR_LOAD, e4, e5, e6};
    for (int k = 0; k < n_states; k++) begin
      opcode    = (k >= 3) ? op : ~op;
      alu_carry = (k == 5) ? c : ~c;
      alu_zero  = (k == 5) ? z : ~z;
      if (k == freeze_at) begin
        en = 1'b0;
        for (int f = 0; f < 3; f++) begin
          #1;
          check({tag, "_frz_t"}, t_state, 32'(6'b1 << k));
          check({tag, "_frz_strb"}, strb, 0);
          check({tag, "_frz_flags"}, {flag_c, flag_z}, {fc_m, fz_m});
          step();
        end
        en = 1'b1;
      end
      #1;
      check({tag, "_t"}, t_state, 32'(6'b1 << k));
      check({tag, "_strb"}, strb, exp_s[k]);
      check({tag, "_flags"}, {flag_c, flag_z}, {fc_m, fz_m});
      check({tag, "_halted"}, halted, 0);
      step();
    end
    if (n_states == 6) begin
      if (op == 4'h1 || op == 4'h2) begin
        fc_m = c;
        fz_m = z;
      end
      check({tag, "_end_t"}, t_state, 6'b000001);
      check({tag, "_end_flags"}, {flag_c, flag_z}, {fc_m, fz_m});
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; opcode = 4'h0; alu_carry = 1'b0; alu_zero = 1'b0;
    repeat (2) step();
    check("rst_t", t_state, 6'b000001);
    check("rst_strb", strb, 0);
    check("rst_flags", {flag_c, flag_z}, 2'b00);
    check("rst_halted", halted, 0);
    rst_n = 1'b1;

    instr("lda", 4'h0, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, NONE, 1'b1, 1'b1, -1, 6);
    instr("add_c", 4'h1, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | ALU_SUM | A_LOAD, 1'b1, 1'b0, -1, 6);
    instr("sub_z", 4'h2, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | ALU_SUB | A_LOAD, 1'b0, 1'b1, -1, 6);
    instr("jz_take", 4'h5, IR_OUT | PC_LOAD, NONE, NONE, 1'b1, 1'b0, -1, 6);
    instr("jc_skip", 4'h4, NONE, NONE, NONE, 1'b1, 1'b1, -1, 6);
    instr("add_00", 4'h1, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | ALU_SUM | A_LOAD, 1'b0, 1'b0, -1, 6);
    instr("jz_skip", 4'h5, NONE, NONE, NONE, 1'b1, 1'b1, -1, 6);
    instr("add_11", 4'h1, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | ALU_SUM | A_LOAD, 1'b1, 1'b1, -1, 6);
    instr("jc_take", 4'h4, IR_OUT | PC_LOAD, NONE, NONE, 1'b0, 1'b0, -1, 6);
    instr("out", 4'hE, A_OUT | OUT_LOAD, NONE, NONE, 1'b0, 1'b0, -1, 6);
    instr("jmp", 4'h3, IR_OUT | PC_LOAD, NONE, NONE, 1'b0, 1'b0, -1, 6);
    instr("nop9", 4'h9, NONE, NONE, NONE, 1'b0, 1'b0, -1, 6);
    instr("add_frz", 4'h1, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | ALU_SUM | A_LOAD, 1'b0, 1'b0, 4, 6);

    instr("hlt", 4'hF, NONE, NONE, NONE, 1'b0, 1'b0, -1, 4);
    check("hlt_halted", halted, 1);
    check("hlt_t", t_state, 6'b001000);
    repeat (20) step();
    check("hlt_hold_t", t_state, 6'b001000);
    check("hlt_hold_strb", strb, 0);
    check("hlt_hold_halted", halted, 1);

    rst_n = 1'b0;
    #2;
    check("hlt_rst_halted", halted, 0);
    check("hlt_rst_t", t_state, 6'b000001);
    check("hlt_rst_strb", strb, 0);
    step();
    rst_n = 1'b1;
    fc_m = 1'b0;
    fz_m = 1'b0;
    instr("post_rst", 4'h0, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, NONE, 1'b0, 1'b0, -1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
